seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational ALU. Operand width is configurable.
- Adds iterative shifts and a shift-add multiplier.
- Uses a valid/ready handshake on both input and output. Result and flags are registered and held until consumed.
- Sits between the decode stage and writeback in the npc datapath as the integer execute unit.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 4 and a power of two.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0] (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op bundle valid.
- in_ready  output  1  unit can accept a bundle (high only in IDLE).
- op  input  4  operation code (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- carry  output  1  carry-out (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB only).
- zero  output  1  result == 0.
- err  output  1  illegal op code.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE; in_ready=1 (combinationally derived from IDLE).
  - out_valid=0, result=0, carry=0, overflow=0, zero=0, err=0.
  - Reset wins over every other event, including in the middle of BUSY or DONE. Any in-flight operation is discarded and no out_valid pulse is produced.
- Handshake:
  - Accept occurs when in_valid && in_ready at a clk edge; a, b and op are captured on that edge.
  - Output transfer occurs when out_valid && out_ready.
  - result and flags stay stable while out_valid=1 && out_ready=0.
- States:
  - IDLE: on accept, single-cycle ops go to DONE with the registered result. Shift ops go to BUSY, or to DONE if the shift amount is 0. MUL goes to BUSY.
  - BUSY: one iteration per cycle; a down-counter holds the remaining iterations. When the counter reaches 0, the state goes to DONE.
  - DONE: out_valid=1; on out_ready the state goes to IDLE.
  - No new accept is possible in DONE or BUSY, so peak throughput is one op per 2 cycles.
- Op codes and latency (N = first cycle, counted after the accept cycle, in which out_valid=1):
  - 0 ADD: {carry,sum} = a + b. N=1.
  - 1 SUB: a + ~b + 1; carry=1 means no borrow. N=1.
  - 2 NOT: ~a. N=1.
  - 3 AND. N=1.
  - 4 OR. N=1.
  - 5 XOR. N=1.
  - 6 SLT: signed a<b; result = {0…, sum_msb ^ overflow}, using the SUB datapath. N=1.
  - 7 EQ: result = {0…, a==b}. N=1.
  - 8 SLL, 9 SRL, 10 SRA: shift by s = b[SHW-1:0], one bit per BUSY cycle. N = s+1; s=0 gives N=1 with result=a.
  - 11 MUL: low WIDTH bits of the unsigned product via shift-add. N = WIDTH+1 regardless of operand values.
  - 12–15: illegal. result=0, err=1, zero=1. N=1.
- Flags:
  - overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is b for ADD and ~b for SUB.
  - carry and overflow are 0 for all ops except ADD/SUB.
  - zero is valid for every op.
  - err is 0 for legal ops.
  - All flags are registered together with result.
- Arithmetic is modulo 2^WIDTH; no widening of result.
- Inputs are ignored while in_ready=0, even if in_valid is high.

Decomposition:
- Package alu_pkg:
  - op_e enum: ADD…MUL, with the illegal range defined.
  - state_e enum: IDLE, BUSY, DONE.
  - Localparam OP_W=4.
- Sub-module alu_comb (purely combinational): computes the single-cycle ops and the carry/overflow/zero flags for WIDTH bits.
- seq_alu owns the FSM, operand/accumulator registers, iteration counter and the shift/multiply datapath.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 -> result=0x80, carry=0, overflow=1, zero=0, out_valid 1 cycle after accept.
- SUB a=0x05 b=0x05 -> result=0x00, carry=1, overflow=0, zero=1; SLT a=0x80 b=0x01 -> result=0x01.
- MUL a=13 b=11 -> result=0x8F, out_valid first high exactly 9 cycles after accept, in_ready=0 throughout.
- SRA a=0x90 b=0x03 -> result=0xF2 at N=4; SLL with b=0x08 (s=0) -> result=a at N=1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 0x10+0x20 -> result=0x30 stable, in_ready=0, second in_valid ignored. Release -> IDLE next cycle.
- Assert rst on the 4th BUSY cycle of MUL -> next cycle out_valid=0, result=0, in_ready=1. op=0xD -> err=1, result=0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential integer execute unit: op codes, FSM states
// and the op-code field width.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_NOT   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_EQ    = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_MUL   = 4'd11,
    OP_ILL12 = 4'd12,
    OP_ILL13 = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic is_shift(input op_e op);
    return op inside {OP_SLL, OP_SRL, OP_SRA};
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU slice: logic ops, add/sub/compare and their flags.
// Shifts return a unshifted (the zero-distance case); MUL is owned by seq_alu.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  // SLT shares the subtractor: a + ~b + 1
  assign sub   = op inside {OP_SUB, OP_SLT};
  assign b_eff = sub ? ~b : b;
  assign {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    err      = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result   = sum;
        carry    = c_out;
        overflow = ovf;
      end
      OP_NOT: result = ~a;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_EQ:  result = {{(WIDTH-1){1'b0}}, a == b};
      OP_SLL, OP_SRL, OP_SRA: result = a;
      OP_MUL: result = '0;
      default: err = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle integer execute unit: valid/ready in and out, single-cycle ops
// via alu_comb, iterative one-bit-per-cycle shifts and a shift-add multiplier.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = SHW + 1;

  state_e           state, state_nxt;
  op_e              op_in, op_q;
  logic [WIDTH-1:0] acc, acc_nxt, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic [SHW-1:0]   shamt;
  logic             iter_start;
  logic             last_iter;

  logic [WIDTH-1:0] c_result;
  logic             c_carry, c_overflow, c_zero, c_err;

  assign op_in      = op_e'(op);
  assign shamt      = b[SHW-1:0];
  assign iter_start = (op_in == OP_MUL) || (is_shift(op_in) && (shamt != '0));
  // The iteration that drives the counter to 0 is the last one
  assign last_iter  = (cnt == CNT_W'(1));

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (op_in),
    .a        (a),
    .b        (b),
    .result   (c_result),
    .carry    (c_carry),
    .overflow (c_overflow),
    .zero     (c_zero),
    .err      (c_err)
  );

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = iter_start ? BUSY : DONE;
      BUSY: if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_comb begin
    acc_nxt = acc;
    case (op_q)
      OP_SLL: acc_nxt = acc << 1;
      OP_SRL: acc_nxt = acc >> 1;
      OP_SRA: acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_MUL: acc_nxt = mplier[0] ? acc + mcand : acc;
      default: acc_nxt = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_ADD;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= op_in;
          acc    <= (op_in == OP_MUL) ? '0 : a;
          mcand  <= a;
          mplier <= b;
          cnt    <= (op_in == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
          if (!iter_start) begin
            result   <= c_result;
            carry    <= c_carry;
            overflow <= c_overflow;
            zero     <= c_zero;
            err      <= c_err;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (last_iter) begin
            result   <= acc_nxt;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= (acc_nxt == '0);
            err      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
